sorteio_papeis: RTL and testbench
=================================

# sorteio_papeis

Role-assignment and player-sequencing datapath for the werewolf game, directly downstream of the game control unit. It keeps a free-running seed counter, latches the seed when the controller pulses `e_seed_reg`, and shuffles the role deck across all players with an LFSR-driven Fisher–Yates pass. It also owns the night-turn player counter: it consumes `zera_CJ`/`inc_jogador`, returns `CJ_fim` to the controller, and presents the current player's role.

## Interface
- `N_JOGADORES`, 8: number of players; legal range 2–16.
- `N_LOBOS`, 2: werewolves in the deck; ≥1 and ≤ `N_JOGADORES`−2.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `rst_global` in 1: synchronous clear of FSM, deck and player counter; seed counter is not affected.
- `zera_CS` in 1: synchronous clear of the seed counter.
- `e_seed_reg` in 1: latch seed and start the shuffle; honoured only in OCIOSO.
- `zera_CJ` in 1: clear the player counter.
- `inc_jogador` in 1: advance the player counter.
- `CJ_fim` out 1: current player is the last one.
- `jogador_atual` out 4: index of the current player.
- `papel_atual` out 2: role of `jogador_atual`.
- `pronto` out 1: shuffle complete, deck valid.
- `db_estado` out 3: FSM state, for debug.

## Operation
- Role codes: ALDEAO=0, LOBO=1, VIDENTE=2, MEDICO=3.
- Seed counter: 16-bit, increments every clock and wraps. `zera_CS` loads 0.
- Seed latch: on `e_seed_reg` in OCIOSO, the seed register captures the pre-edge counter value. The LFSR loads that seed, or 0xACE1 if the seed is 0.
- LFSR: 16-bit Galois, taps mask 0xB400. It advances once per SORTEIA cycle only.
- FSM states: OCIOSO(0) → CARREGA(1) → SORTEIA(2) ⇄ TROCA(3) → PRONTO(4).
  - CARREGA: deck slots 0..N_LOBOS−1 are LOBO, the next slot is VIDENTE, the next is MEDICO, the rest are ALDEAO. Sets i = N_JOGADORES−1.
  - SORTEIA: j = (lfsr[7:0] × (i+1)) >> 8. The product is 13 bits wide and j ∈ [0, i]. j is registered.
  - TROCA: swap deck[i] and deck[j], then decrement i. If the old i was 1, go to PRONTO; otherwise return to SORTEIA.
  - PRONTO: hold. `e_seed_reg` is ignored. Only `rst_global` or `reset` return the FSM to OCIOSO.
- `e_seed_reg` outside OCIOSO is ignored.
- Player counter:
  - `zera_CJ` loads `jogador_atual` = 0 and sets an internal `primeiro` flag.
  - `inc_jogador` while `primeiro`=1 keeps 0 and clears the flag; otherwise it increments, wrapping N_JOGADORES−1 → 0.
  - `zera_CJ` wins over a simultaneous `inc_jogador`.
  - The counter operates regardless of FSM state.
- `CJ_fim` = !`primeiro` && `jogador_atual` == N_JOGADORES−1. It is combinational from registers.
- `papel_atual` = `pronto` ? deck[`jogador_atual`] : ALDEAO.
- `rst_global` mid-shuffle aborts the shuffle: FSM → OCIOSO, deck cleared to ALDEAO, counter 0, `primeiro`=1.

## Timing
- Reset values (`reset` or `rst_global`): FSM OCIOSO, `pronto`=0, `jogador_atual`=0, `primeiro`=1, `CJ_fim`=0, `papel_atual`=0, `db_estado`=0, deck all ALDEAO. `reset` additionally clears the seed counter, seed register and LFSR to 0.
- Shuffle latency with `e_seed_reg` sampled at edge T:
  - T: enter CARREGA.
  - T+1: enter SORTEIA.
  - Each swap takes 2 cycles.
  - `pronto` rises after edge T+2·N_JOGADORES−1, i.e. T+15 for N=8.
- `zera_CS` and `e_seed_reg` on the same edge: the seed is the pre-clear value.
- Counter update takes effect on the same edge; `CJ_fim` and `papel_atual` follow in the same cycle.

## Configuration
- `SORTEIO_ESPECIAIS_EN` defined: the deck contains one VIDENTE and one MEDICO, as described above.
- `SORTEIO_ESPECIAIS_EN` undefined: only LOBO and ALDEAO are placed, and the constraint relaxes to N_LOBOS ≤ N_JOGADORES−1. All timing is unchanged.

## Structure
- Package `pkg_lobinho` holds:
  - role code constants;
  - FSM state encodings;
  - LFSR tap mask 0xB400;
  - fallback seed 0xACE1.
- Sub-module `lfsr16` (load, enable, 16-bit state out) is instantiated once.
- The deck is a register array of N_JOGADORES × 2 bits. This is not RAM, because swaps need two reads and two writes per cycle.

## Test plan
- Seed 0x0000 latched, N=8 → LFSR loads 0xACE1; `pronto` at T+15; deck holds exactly 2 LOBO, 1 VIDENTE, 1 MEDICO, 4 ALDEAO.
- Same nonzero seed (0x1234) in two runs separated by `rst_global` → identical deck permutation both times.
- `zera_CJ`, then 8 pulses of `inc_jogador` → `jogador_atual` reads 0,0,1,…,7; `CJ_fim`=1 only after the 8th pulse; a 9th pulse wraps to 0 with `CJ_fim`=0.
- `rst_global` in the 4th SORTEIA cycle → next cycle OCIOSO, `pronto`=0, `papel_atual`=0; a new `e_seed_reg` restarts with the full latency.
- `e_seed_reg` pulsed during TROCA and during PRONTO → ignored; the deck is unchanged.
- Macro undefined, N_LOBOS=2 → deck holds 2 LOBO, 6 ALDEAO, with no VIDENTE or MEDICO.

Source files
------------

// File: rtl/pkg_lobinho.sv
// -----------------------------------------------------------------------------
// pkg_lobinho
// Shared definitions for the werewolf role-assignment datapath:
//   - role codes (papel_t)
//   - shuffle FSM state encodings (estado_t)
//   - Galois LFSR tap mask and the fallback seed used when the latched seed is 0
//   - lfsr_next(): one Galois step of the 16-bit LFSR
// -----------------------------------------------------------------------------
package pkg_lobinho;

    typedef enum logic [1:0] {
        ALDEAO  = 2'd0,
        LOBO    = 2'd1,
        VIDENTE = 2'd2,
        MEDICO  = 2'd3
    } papel_t;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        SORTEIA = 3'd2,
        TROCA   = 3'd3,
        PRONTO  = 3'd4
    } estado_t;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] SEED_FALLBACK = 16'hACE1;

    // Galois form: shift right, fold the taps in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR (taps 0xB400) with synchronous load and step enable.
// Ports:
//   clock     in  system clock, rising edge
//   reset     in  asynchronous, active-high; clears the state to 0
//   i_load    in  load i_seed (has priority over i_enable)
//   i_enable  in  advance one step
//   i_seed    in  value loaded on i_load
//   o_estado  out current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
    import pkg_lobinho::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_enable,
    input  logic [15:0] i_seed,
    output logic [15:0] o_estado
);

    logic [15:0] r_estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= 16'd0;
        end else if (i_load) begin
            r_estado <= i_seed;
        end else if (i_enable) begin
            r_estado <= lfsr_next(r_estado);
        end
    end

    assign o_estado = r_estado;

endmodule

// File: rtl/sorteio_papeis.sv
// -----------------------------------------------------------------------------
// sorteio_papeis
// Role-assignment and player-sequencing datapath for the werewolf game.
// A free-running 16-bit seed counter is latched on e_seed_reg (only in
// OCIOSO); the role deck is then filled and shuffled with an LFSR-driven
// Fisher-Yates pass. The block also owns the night-turn player counter.
//
// Configuration macro: SORTEIO_ESPECIAIS_EN
//   defined   : deck = N_LOBOS x LOBO, 1 VIDENTE, 1 MEDICO, rest ALDEAO
//   undefined : deck = N_LOBOS x LOBO, rest ALDEAO (timing unchanged)
//
// Parameters:
//   N_JOGADORES  number of players, 2..16
//   N_LOBOS      werewolves, >=1 and <= N_JOGADORES-2 (N_JOGADORES-1 when
//                SORTEIO_ESPECIAIS_EN is undefined)
// Ports:
//   clock          in  system clock, rising edge
//   reset          in  asynchronous, active-high; clears everything
//   rst_global     in  synchronous clear of FSM, deck and player counter
//   zera_CS        in  synchronous clear of the seed counter
//   e_seed_reg     in  latch seed and start shuffling (OCIOSO only)
//   zera_CJ        in  clear player counter, set "first" flag
//   inc_jogador    in  advance player counter
//   CJ_fim         out current player is the last one
//   jogador_atual  out current player index
//   papel_atual    out role of current player (ALDEAO until deck valid)
//   pronto         out shuffle complete, deck valid
//   db_estado      out FSM state, debug
// -----------------------------------------------------------------------------
module sorteio_papeis
    import pkg_lobinho::*;
#(
    parameter int N_JOGADORES = 8,
    parameter int N_LOBOS     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rst_global,
    input  logic       zera_CS,
    input  logic       e_seed_reg,
    input  logic       zera_CJ,
    input  logic       inc_jogador,
    output logic       CJ_fim,
    output logic [3:0] jogador_atual,
    output logic [1:0] papel_atual,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam logic [3:0] ULTIMO = 4'(N_JOGADORES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0] r_seed_cnt;
    logic [15:0] r_seed;
    estado_t     r_estado;
    logic        r_pronto;
    logic [3:0]  r_i;
    logic [3:0]  r_j;
    papel_t      r_deck [N_JOGADORES];
    logic [3:0]  r_jogador;
    logic        r_primeiro;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic [15:0] w_lfsr;
    logic [15:0] w_lfsr_seed;
    logic        w_lfsr_load;
    logic        w_lfsr_en;
    logic [12:0] w_prod;
    papel_t      w_deck_i;
    papel_t      w_deck_j;
    papel_t      w_deck_jog;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Seed counter: free-running, unaffected by rst_global.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seed_cnt <= 16'd0;
        end else if (zera_CS) begin
            r_seed_cnt <= 16'd0;
        end else begin
            r_seed_cnt <= r_seed_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // LFSR. It is loaded during CARREGA from the latched seed; the first
    // value consumed is in the following SORTEIA cycle, so loading one
    // cycle after the latch is indistinguishable from loading at the latch.
    // ------------------------------------------------------------------
    assign w_lfsr_seed = (r_seed == 16'd0) ? SEED_FALLBACK : r_seed;
    assign w_lfsr_load = (r_estado == CARREGA) && !rst_global;
    assign w_lfsr_en   = (r_estado == SORTEIA) && !rst_global;

    lfsr16 u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_lfsr_load),
        .i_enable (w_lfsr_en),
        .i_seed   (w_lfsr_seed),
        .o_estado (w_lfsr)
    );

    // j = (lfsr[7:0] * (i+1)) >> 8 lies in [0, i], so bits [11:8] suffice;
    // bit 12 is always 0 because i+1 <= 16.
    assign w_prod = 13'(w_lfsr[7:0]) * 13'({1'b0, r_i} + 5'd1);

    // Deck read ports: two for the swap, one for the current player.
    always_comb begin
        w_deck_i   = ALDEAO;
        w_deck_j   = ALDEAO;
        w_deck_jog = ALDEAO;
        for (int k = 0; k < N_JOGADORES; k++) begin
            if (r_i == 4'(k))       w_deck_i   = r_deck[k];
            if (r_j == 4'(k))       w_deck_j   = r_deck[k];
            if (r_jogador == 4'(k)) w_deck_jog = r_deck[k];
        end
    end

    // ------------------------------------------------------------------
    // Shuffle FSM with deck, indices and pronto as registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_pronto <= 1'b0;
            r_i      <= 4'd0;
            r_j      <= 4'd0;
            r_seed   <= 16'd0;
            for (int k = 0; k < N_JOGADORES; k++) r_deck[k] <= ALDEAO;
        end else if (rst_global) begin
            // Aborts any shuffle in progress; the seed register is kept.
            r_estado <= OCIOSO;
            r_pronto <= 1'b0;
            r_i      <= 4'd0;
            r_j      <= 4'd0;
            for (int k = 0; k < N_JOGADORES; k++) r_deck[k] <= ALDEAO;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (e_seed_reg) begin
                        r_seed   <= r_seed_cnt;
                        r_estado <= CARREGA;
                    end
                end
                CARREGA: begin
                    for (int k = 0; k < N_JOGADORES; k++) begin
                        if (k < N_LOBOS) begin
                            r_deck[k] <= LOBO;
`ifdef SORTEIO_ESPECIAIS_EN
                        end else if (k == N_LOBOS) begin
                            r_deck[k] <= VIDENTE;
                        end else if (k == N_LOBOS + 1) begin
                            r_deck[k] <= MEDICO;
`endif
                        end else begin
                            r_deck[k] <= ALDEAO;
                        end
                    end
                    r_i      <= ULTIMO;
                    r_estado <= SORTEIA;
                end
                SORTEIA: begin
                    r_j      <= w_prod[11:8];
                    r_estado <= TROCA;
                end
                TROCA: begin
                    // When i == j the first branch rewrites the slot with itself.
                    for (int k = 0; k < N_JOGADORES; k++) begin
                        if (r_i == 4'(k)) begin
                            r_deck[k] <= w_deck_j;
                        end else if (r_j == 4'(k)) begin
                            r_deck[k] <= w_deck_i;
                        end
                    end
                    r_i <= r_i - 4'd1;
                    if (r_i == 4'd1) begin
                        r_estado <= PRONTO;
                        r_pronto <= 1'b1;
                    end else begin
                        r_estado <= SORTEIA;
                    end
                end
                PRONTO: begin
                    r_estado <= PRONTO;
                end
                default: begin
                    r_estado <= OCIOSO;
                    r_pronto <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Player counter. The "primeiro" flag makes the first inc_jogador after
    // zera_CJ stay on player 0, so a full round is N_JOGADORES pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_jogador  <= 4'd0;
            r_primeiro <= 1'b1;
        end else if (rst_global || zera_CJ) begin
            r_jogador  <= 4'd0;
            r_primeiro <= 1'b1;
        end else if (inc_jogador) begin
            if (r_primeiro) begin
                r_primeiro <= 1'b0;
            end else if (r_jogador == ULTIMO) begin
                r_jogador <= 4'd0;
            end else begin
                r_jogador <= r_jogador + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign CJ_fim        = !r_primeiro && (r_jogador == ULTIMO);
    assign jogador_atual = r_jogador;
    assign papel_atual   = r_pronto ? w_deck_jog : ALDEAO;
    assign pronto        = r_pronto;
    assign db_estado     = r_estado;

    // Upper LFSR bits only feed the next LFSR state; product bit 12 is always 0.
    assign w_unused = ^{w_lfsr[15:8], w_prod[12]};

endmodule

// File: tb/tb_sorteio_papeis.sv
module tb_sorteio_papeis;

  localparam int N  = 8;
  localparam int NL = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       rst_global;
  logic       zera_CS;
  logic       e_seed_reg;
  logic       zera_CJ;
  logic       inc_jogador;
  logic       CJ_fim;
  logic [3:0] jogador_atual;
  logic [1:0] papel_atual;
  logic       pronto;
  logic [2:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] exp_deck [N];
  logic [1:0] got_deck [N];
  logic [1:0] first_deck [N];

  typedef struct {
    logic       zera;
    logic       inc;
    logic [3:0] jog;
    logic       fim;
    logic [1:0] papel;
  } vec_t;

  vec_t tbl [13];

  sorteio_papeis #(.N_JOGADORES(N), .N_LOBOS(NL)) dut (
    .clock         (clock),
    .reset         (reset),
    .rst_global    (rst_global),
    .zera_CS       (zera_CS),
    .e_seed_reg    (e_seed_reg),
    .zera_CJ       (zera_CJ),
    .inc_jogador   (inc_jogador),
    .CJ_fim        (CJ_fim),
    .jogador_atual (jogador_atual),
    .papel_atual   (papel_atual),
    .pronto        (pronto),
    .db_estado     (db_estado)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: Fisher-Yates from the spec's LFSR and index formula.
  task automatic build_exp(input logic [15:0] seed);
    logic [15:0] s;
    logic [1:0]  t;
    int          j;
    for (int k = 0; k < N; k++) begin
      if (k < NL) exp_deck[k] = 2'd1;
`ifdef SORTEIO_ESPECIAIS_EN
      else if (k == NL) exp_deck[k] = 2'd2;
      else if (k == NL + 1) exp_deck[k] = 2'd3;
`endif
      else exp_deck[k] = 2'd0;
    end
    s = (seed == 16'd0) ? 16'hACE1 : seed;
    for (int i = N - 1; i >= 1; i--) begin
      j = (int'(s[7:0]) * (i + 1)) / 256;
      if (s[0]) s = (s >> 1) ^ 16'hB400;
      else      s = s >> 1;
      t = exp_deck[i];
      exp_deck[i] = exp_deck[j];
      exp_deck[j] = t;
    end
  endtask

  // Driver: zero the seed counter, let it reach 'seed', then latch it.
  task automatic start_seed(input int seed);
    zera_CS = 1'b1;
    tick();
    zera_CS = 1'b0;
    repeat (seed) tick();
    e_seed_reg = 1'b1;
    tick();
    e_seed_reg = 1'b0;
    chk("state_after_start", 32'(db_estado), 32'd1);
  endtask

  // Wait (bounded) for pronto; optionally pulse e_seed_reg once during TROCA.
  task automatic wait_pronto(input string name, input bit inject_troca);
    int n;
    bit injected;
    n = 0;
    injected = 1'b0;
    while (!pronto && n < 40) begin
      if (inject_troca && !injected && db_estado == 3'd3) begin
        e_seed_reg = 1'b1;
        injected = 1'b1;
      end
      tick();
      e_seed_reg = 1'b0;
      n++;
    end
    chk(name, 32'(n), 32'd15);
    chk({name, "_state"}, 32'(db_estado), 32'd4);
  endtask

  // Walk the player counter through a full round, capturing each role.
  task automatic read_deck();
    zera_CJ = 1'b1;
    tick();
    zera_CJ = 1'b0;
    inc_jogador = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      got_deck[k] = papel_atual;
      chk("read_jog", 32'(jogador_atual), 32'(k));
      tick();
    end
    inc_jogador = 1'b0;
  endtask

  task automatic cmp_deck(input string name);
    for (int k = 0; k < N; k++) chk(name, 32'(got_deck[k]), 32'(exp_deck[k]));
  endtask

  task automatic chk_composition();
    int c [4];
    for (int r = 0; r < 4; r++) c[r] = 0;
    for (int k = 0; k < N; k++) c[got_deck[k]]++;
    chk("cnt_lobo", 32'(c[1]), 32'(NL));
`ifdef SORTEIO_ESPECIAIS_EN
    chk("cnt_vidente", 32'(c[2]), 32'd1);
    chk("cnt_medico", 32'(c[3]), 32'd1);
    chk("cnt_aldeao", 32'(c[0]), 32'(N - NL - 2));
`else
    chk("cnt_vidente", 32'(c[2]), 32'd0);
    chk("cnt_medico", 32'(c[3]), 32'd0);
    chk("cnt_aldeao", 32'(c[0]), 32'(N - NL));
`endif
  endtask

  initial begin
    int cnt;

    reset = 1'b1;
    rst_global = 1'b0;
    zera_CS = 1'b0;
    e_seed_reg = 1'b0;
    zera_CJ = 1'b0;
    inc_jogador = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_jog", 32'(jogador_atual), 32'd0);
    chk("rst_fim", 32'(CJ_fim), 32'd0);
    chk("rst_papel", 32'(papel_atual), 32'd0);

    // Player counter table (deck not valid -> papel stays ALDEAO)
    tbl[0] = '{1'b1, 1'b0, 4'd0, 1'b0, 2'd0};
    tbl[1] = '{1'b0, 1'b1, 4'd0, 1'b0, 2'd0};
    for (int k = 2; k <= 8; k++) tbl[k] = '{1'b0, 1'b1, 4'(k - 1), (k == 8), 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 4'd0, 1'b0, 2'd0};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 1'b1, 4'd1, 1'b0, 2'd0};
    tbl[12] = '{1'b1, 1'b1, 4'd0, 1'b0, 2'd0};
    for (int v = 0; v < 13; v++) begin
      zera_CJ = tbl[v].zera;
      inc_jogador = tbl[v].inc;
      tick();
      chk("tbl_jog", 32'(jogador_atual), 32'(tbl[v].jog));
      chk("tbl_fim", 32'(CJ_fim), 32'(tbl[v].fim));
      chk("tbl_papel", 32'(papel_atual), 32'(tbl[v].papel));
    end
    zera_CJ = 1'b0;
    inc_jogador = 1'b0;

    // Seed 0 -> fallback seed, latency, composition, permutation
    start_seed(0);
    wait_pronto("lat_seed0", 1'b0);
    chk("pronto_seed0", 32'(pronto), 32'd1);
    build_exp(16'h0000);
    read_deck();
    chk_composition();
    cmp_deck("deck_seed0");

    // e_seed_reg in PRONTO is ignored
    e_seed_reg = 1'b1;
    tick();
    e_seed_reg = 1'b0;
    repeat (3) tick();
    chk("pronto_hold_state", 32'(db_estado), 32'd4);
    read_deck();
    cmp_deck("deck_after_pronto_seed");

    // Seed 0x1234 twice, separated by rst_global; second run pokes TROCA
    rst_global = 1'b1;
    tick();
    rst_global = 1'b0;
    chk("rg_estado", 32'(db_estado), 32'd0);
    chk("rg_pronto", 32'(pronto), 32'd0);
    start_seed(16'h1234);
    wait_pronto("lat_1234a", 1'b0);
    build_exp(16'h1234);
    read_deck();
    cmp_deck("deck_1234a");
    for (int k = 0; k < N; k++) first_deck[k] = got_deck[k];
    rst_global = 1'b1;
    tick();
    rst_global = 1'b0;
    start_seed(16'h1234);
    wait_pronto("lat_1234b_troca_poke", 1'b1);
    read_deck();
    for (int k = 0; k < N; k++) chk("deck_repeat", 32'(got_deck[k]), 32'(first_deck[k]));

    // rst_global during the 4th SORTEIA cycle aborts the shuffle
    rst_global = 1'b1;
    tick();
    rst_global = 1'b0;
    start_seed(16'h0042);
    cnt = 0;
    for (int n = 0; n < 20 && cnt < 4; n++) begin
      tick();
      if (db_estado == 3'd2) cnt++;
    end
    chk("abort_found_4th_sorteia", 32'(cnt), 32'd4);
    rst_global = 1'b1;
    tick();
    rst_global = 1'b0;
    chk("abort_estado", 32'(db_estado), 32'd0);
    chk("abort_pronto", 32'(pronto), 32'd0);
    chk("abort_papel", 32'(papel_atual), 32'd0);
    chk("abort_jog", 32'(jogador_atual), 32'd0);
    start_seed(16'h0042);
    wait_pronto("lat_restart", 1'b0);
    build_exp(16'h0042);
    read_deck();
    cmp_deck("deck_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
